// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM state
// encoding, default latencies and the counter sizing helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Down-counter must hold the longer latency; never narrower than 4 bits.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int mx;
    int w;
    mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w  = $clog2(mx + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
// Divide by zero returns the current {hi, lo} so completion leaves them unchanged.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_signed_div;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;

  always_comb begin
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without any signed overflow.
    is_signed_div = (op == MD_DIV);
    num = (is_signed_div && a[31]) ? (~a + 32'd1) : a;
    den = (is_signed_div && b[31]) ? (~b + 32'd1) : b;
    if (den != 32'd0) begin
      q_mag = num / den;
      r_mag = num % den;
    end else begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end

    q_res = q_mag;
    r_res = r_mag;
    if (is_signed_div) begin
      if (a[31] ^ b[31]) q_res = ~q_mag + 32'd1;
      if (a[31])         r_res = ~r_mag + 32'd1;
    end

    res = {hi, lo};
    case (op)
      MD_MULT:          res = prod_s;
      MD_MULTU:         res = prod_u;
      MD_DIV, MD_DIVU:  if (b != 32'd0) res = {r_res, q_res};
      default:          res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle ops issued in E
// and stalls a dependent mult/div-class instruction held in D.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_e   dbg_state
);

  localparam int CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  md_state_e     state;
  logic [CW-1:0] cnt;
  logic [31:0]   phi;
  logic [31:0]   plo;
  logic [63:0]   arith_res;

  md_arith u_arith (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi),
    .lo  (lo),
    .res (arith_res)
  );

  // Result is captured at issue; HI/LO only change at the final busy edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      phi   <= '0;
      plo   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        case (op)
          MD_MULT, MD_MULTU: begin
            {phi, plo} <= arith_res;
            cnt        <= MULT_LOAD;
            state      <= MD_BUSY;
          end
          MD_DIV, MD_DIVU: begin
            {phi, plo} <= arith_res;
            cnt        <= DIV_LOAD;
            state      <= MD_BUSY;
          end
          MD_MTHI: hi <= a;
          MD_MTLO: lo <= a;
          default: ;
        endcase
      end
    end else begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        hi    <= phi;
        lo    <= plo;
        state <= MD_IDLE;
      end
    end
  end

  assign busy      = (state == MD_BUSY);
  assign stall_d   = ~reset & md_use_d & (start | busy);
  assign dbg_state = state;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: scoreboard queue of expected {hi, lo}
// pushed at issue and popped when the operation's result becomes visible.
module tb_md_sched;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .md_use_d  (md_use_d),
    .busy      (busy),
    .stall_d   (stall_d),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Protocol monitor: a start must never be presented while busy.
  always @(posedge clk) begin
    if (!reset && busy && start) begin
      errors++;
      $display("FAIL start_while_busy: start=1 busy=1 at %0t, required no overlap", $time);
    end
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] h,
                                        input logic [31:0] l);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [31:0] q;
    logic signed [31:0] r;
    case (o)
      MD_MULT: begin
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
      end
      MD_MULTU: return {32'd0, x} * {32'd0, y};
      MD_DIV: begin
        if (y == 32'd0) return {h, l};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      MD_DIVU: begin
        if (y == 32'd0) return {h, l};
        return {x % y, x / y};
      end
      MD_MTHI: return {x, l};
      MD_MTLO: return {h, x};
      default: return {h, l};
    endcase
  endfunction

  // Issues a multi-cycle op in the current (low-phase) cycle t and follows it
  // through completion; returns in cycle t+N+1 so a back-to-back issue can follow.
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic use_i, input string name);
    int n;
    logic [63:0] e;
    n = (op_i == MD_MULT || op_i == MD_MULTU) ? MULT_N : DIV_N;
    exp_q.push_back(model(op_i, a_i, b_i, model_hi, model_lo));
    start = 1'b1; op = op_i; a = a_i; b = b_i; md_use_d = use_i;
    #1;
    checks++;
    if (stall_d !== use_i) begin
      errors++;
      $display("FAIL %s stall_issue: got %b, expected %b", name, stall_d, use_i);
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || stall_d !== use_i || dbg_state !== MD_BUSY) begin
        errors++;
        $display("FAIL %s busy_cycle%0d: busy=%b stall_d=%b state=%0d, expected busy=1 stall_d=%b state=1",
                 name, i, busy, stall_d, dbg_state, use_i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || stall_d !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags: busy=%b stall_d=%b, expected 0 0", name, busy, stall_d);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
    end
    model_hi = e[63:32];
    model_lo = e[31:0];
    md_use_d = 1'b0;
  endtask

  task automatic mt_op(input logic [2:0] op_i, input logic [31:0] a_i, input string name);
    logic [63:0] e;
    exp_q.push_back(model(op_i, a_i, 32'd0, model_hi, model_lo));
    start = 1'b1; op = op_i; a = a_i; b = 32'd0; md_use_d = 1'b0;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin
      errors++;
      $display("FAIL %s stall: got %b, expected 0", name, stall_d);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== e) begin
      errors++;
      $display("FAIL %s update: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h",
               name, busy, hi, lo, e[63:32], e[31:0]);
    end
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use_d = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall_d !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || dbg_state !== MD_IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b stall_d=%b hi=%h lo=%h state=%0d, expected all 0",
               busy, stall_d, hi, lo, dbg_state);
    end
    start = 1'b1; op = MD_MTHI; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0; md_use_d = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: hi=%h busy=%b, expected hi=0 busy=0", hi, busy);
    end
  endtask

  task automatic test_mult();
    @(negedge clk);
    run_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b1, "mult");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL mult_const: hi=%h lo=%h, expected ffffffff fffffffe", hi, lo);
    end
    @(negedge clk);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0, "multu");
    checks++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_const: hi=%h lo=%h, expected 00000001 fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    @(negedge clk);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1, "div_neg");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg_const: hi=%h lo=%h, expected ffffffff fffffffd", hi, lo);
    end
    @(negedge clk);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    checks++;
    if (hi !== 32'h00000000 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf_const: hi=%h lo=%h, expected 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_mt_and_divzero();
    @(negedge clk);
    mt_op(MD_MTHI, 32'h00001234, "mthi");
    @(negedge clk);
    mt_op(MD_MTLO, 32'hCAFEF00D, "mtlo");
    checks++;
    if (hi !== 32'h00001234 || lo !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mt_const: hi=%h lo=%h, expected 00001234 cafef00d", hi, lo);
    end
    @(negedge clk);
    mt_op(MD_MTHI, 32'h00000011, "mthi11");
    @(negedge clk);
    mt_op(MD_MTLO, 32'h00000022, "mtlo22");
    @(negedge clk);
    run_op(MD_DIVU, 32'd7, 32'd0, 1'b1, "divu_zero");
    checks++;
    if (hi !== 32'h00000011 || lo !== 32'h00000022) begin
      errors++;
      $display("FAIL divu_zero_hold: hi=%h lo=%h, expected 00000011 00000022", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op(MD_MULT, 32'h00000003, 32'hFFFFFFFB, 1'b1, "b2b_first");
    run_op(MD_MULT, 32'h12345678, 32'h9ABCDEF0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [2:0]  r_op;
    logic [31:0] r_b;
    for (int k = 0; k < 8; k++) begin
      r_op = 3'($urandom_range(0, 3));
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      @(negedge clk);
      run_op(r_op, $urandom, r_b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7; md_use_d = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_d !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b hi=%h lo=%h stall_d=%b, expected all 0",
               busy, hi, lo, stall_d);
    end
    @(negedge clk);
    reset = 1'b0; md_use_d = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (DIV_N + 2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_complete: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_and_divzero();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
